// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan sequencer: FSM state encoding,
// detector hit code and field widths.
package scan_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 3;

    localparam logic [1:0] HIT_STATE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_e;

    // A requested length of 0 or anything beyond the data width means a full byte.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] req_len);
        if (req_len == '0 || req_len > CNT_W'(DATA_W)) begin
            return CNT_W'(DATA_W);
        end
        return req_len;
    endfunction

endpackage

// File: rtl/scan_seq_ctrl_if.sv
// Signal bundle between the scan sequencer (slave) and its driver/detector
// environment (master).
interface scan_seq_ctrl_if;
    import scan_ctrl_pkg::*;

    // ser_valid qualifies ser_out: while ser_valid=1 the detector must consume
    // ser_out on the next rising edge; there is no ready, the detector never stalls.
    logic                start;
    logic [DATA_W-1:0]   data_in;
    logic [CNT_W-1:0]    len;
    logic [1:0]          det_state;
    logic                ser_out;
    logic                ser_valid;
    logic                det_rst_n;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    hit_count;
    logic [IDX_W-1:0]    first_hit_idx;
    logic                hit_seen;
    scan_state_e         dbg_state;

    modport master (
        output start, data_in, len, det_state,
        input  ser_out, ser_valid, det_rst_n, busy, done,
               hit_count, first_hit_idx, hit_seen, dbg_state
    );

    modport slave (
        input  start, data_in, len, det_state,
        output ser_out, ser_valid, det_rst_n, busy, done,
               hit_count, first_hit_idx, hit_seen, dbg_state
    );

endinterface

// File: rtl/scan_shifter.sv
// Load/shift register and bit counter for the scan sequencer; flags the
// final bit of the captured length.
module scan_shifter
    import scan_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  len_eff,
    output logic              ser_bit,
    output logic [IDX_W-1:0]  bit_idx,
    output logic              last
);

    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  len_q;
    logic [IDX_W-1:0]  cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr    <= '0;
            len_q <= CNT_W'(DATA_W);
            cnt   <= '0;
        end else if (load) begin
            sr    <= data_in;
            len_q <= len_eff;
            cnt   <= '0;
        end else if (shift) begin
            sr    <= {1'b0, sr[DATA_W-1:1]};
            cnt   <= cnt + IDX_W'(1);
        end
    end

    assign ser_bit = sr[0];
    // After a full byte the counter wraps to 0, so bit_idx-1 still names bit 7.
    assign bit_idx = cnt;
    assign last    = (CNT_W'(cnt) == (len_q - CNT_W'(1)));

endmodule

// File: rtl/scan_seq_ctrl.sv
// Scan sequencer: serialises a byte into a downstream Moore detector and
// counts detector entries into HIT_STATE. Optional abort input under SCAN_ABORT_EN.
module scan_seq_ctrl
    import scan_ctrl_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
`ifdef SCAN_ABORT_EN
    input  logic           abort,
`endif
    scan_seq_ctrl_if.slave bus
);

    scan_state_e       state, state_next;
    logic              abort_req;
    logic              load, shift, last, ser_bit;
    logic [IDX_W-1:0]  bit_idx, sample_idx;
    logic              sample_en;
    logic [1:0]        prev_state;
    logic [CNT_W-1:0]  hit_count_q;
    logic [IDX_W-1:0]  first_hit_idx_q;
    logic              hit_seen_q;
    logic              det_rst_n_q;

`ifdef SCAN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign load  = (state == ST_IDLE) && bus.start;
    assign shift = (state == ST_SHIFT);

    scan_shifter u_shifter (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .shift   (shift),
        .data_in (bus.data_in),
        .len_eff (eff_len(bus.len)),
        .ser_bit (ser_bit),
        .bit_idx (bit_idx),
        .last    (last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (bus.start) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_SHIFT;
            ST_SHIFT: if (last) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (abort_req && (state == ST_LOAD || state == ST_SHIFT || state == ST_DRAIN)) begin
            state_next = ST_DONE;
        end
    end

    // The detector is registered, so what we see now reflects the previous bit.
    assign sample_en  = (state == ST_SHIFT && bit_idx != '0) || (state == ST_DRAIN);
    assign sample_idx = bit_idx - IDX_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            det_rst_n_q     <= 1'b1;
            prev_state      <= 2'b00;
            hit_count_q     <= '0;
            first_hit_idx_q <= '0;
            hit_seen_q      <= 1'b0;
        end else begin
            det_rst_n_q <= (state_next != ST_LOAD);
            if (state == ST_LOAD) begin
                prev_state      <= 2'b00;
                hit_count_q     <= '0;
                first_hit_idx_q <= '0;
                hit_seen_q      <= 1'b0;
            end else if (sample_en) begin
                prev_state <= bus.det_state;
                if (bus.det_state == HIT_STATE && prev_state != HIT_STATE) begin
                    if (hit_count_q != '1) hit_count_q <= hit_count_q + CNT_W'(1);
                    if (!hit_seen_q) begin
                        first_hit_idx_q <= sample_idx;
                        hit_seen_q      <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ser_valid     = (state == ST_SHIFT);
    assign bus.ser_out       = (state == ST_SHIFT) && ser_bit;
    assign bus.det_rst_n     = det_rst_n_q;
    assign bus.busy          = (state != ST_IDLE);
    assign bus.done          = (state == ST_DONE);
    assign bus.hit_count     = hit_count_q;
    assign bus.first_hit_idx = first_hit_idx_q;
    assign bus.hit_seen      = hit_seen_q;
    assign bus.dbg_state     = state;

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl with a Moore detector in the loop; the abort
// scenario is included only when SCAN_ABORT_EN is defined.
module tb_scan_seq_ctrl;
    import scan_ctrl_pkg::*;

    logic clock;
    logic reset;
`ifdef SCAN_ABORT_EN
    logic abort;
`endif
    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    scan_seq_ctrl_if bus();

    scan_seq_ctrl dut (
        .clock (clock),
        .reset (reset),
`ifdef SCAN_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- detector model: 00 -0-> 01 -0-> 11, 01 -1-> 10 -0-> 11 ----------------
    function automatic logic [1:0] det_next(input logic [1:0] s, input logic x);
        case (s)
            2'b00:   return x ? 2'b00 : 2'b01;
            2'b01:   return x ? 2'b10 : 2'b11;
            2'b10:   return x ? 2'b00 : 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    logic [1:0] det_q;
    logic       det_clr_n;
    assign det_clr_n = bus.det_rst_n & reset;

    always_ff @(posedge clock or negedge det_clr_n) begin
        if (!det_clr_n)         det_q <= 2'b00;
        else if (bus.ser_valid) det_q <= det_next(det_q, bus.ser_out);
    end
    assign bus.det_state = det_q;

    // Expected {hit_seen, first_hit_idx, hit_count} for a full scan.
    function automatic logic [7:0] model_scan(input logic [7:0] d, input logic [3:0] l);
        int         n;
        logic [1:0] s;
        logic [1:0] p;
        logic [3:0] c;
        logic [2:0] idx;
        logic       seen;
        n = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
        s = 2'b00; p = 2'b00; c = 4'd0; idx = 3'd0; seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            s = det_next(s, d[k]);
            if (s == 2'b11 && p != 2'b11) begin
                if (c != 4'hF) c = c + 4'd1;
                if (!seen) begin
                    seen = 1'b1;
                    idx  = 3'(k);
                end
            end
            p = s;
        end
        return {seen, idx, c};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] results();
        return {bus.hit_seen, bus.first_hit_idx, bus.hit_count};
    endfunction

    // Latency counts rising edges inclusively, from the one that accepts start
    // through the one that raises done.
    task automatic run_scan(input logic [7:0] d, input logic [3:0] l, input bit hold_start,
                            output logic [7:0] res);
        int n;
        int lat;
        int svc;
        bit got;
        n = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
        bus.data_in = d;
        bus.len     = l;
        bus.start   = 1'b1;
        exp_q.push_back(model_scan(d, l));
        @(posedge clock); #1;
        if (!hold_start) bus.start = 1'b0;
        check("load_busy", 16'(bus.busy), 16'd1);
        check("load_det_rst_n", 16'(bus.det_rst_n), 16'd0);
        lat = 1; svc = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clock); #1;
            lat++;
            if (bus.ser_valid) svc++;
            if (bus.done) got = 1'b1;
        end
        bus.start = 1'b0;
        check("done_seen", 16'(got), 16'd1);
        check("done_latency", 16'(lat), 16'(n + 3));
        check("ser_valid_cycles", 16'(svc), 16'(n));
        res = results();
        if (exp_q.size() > 0) check("result", 16'(res), 16'(exp_q.pop_front()));
        @(posedge clock); #1;
        check("after_done_low", 16'(bus.done), 16'd0);
        check("after_idle", 16'(bus.busy), 16'd0);
        check("results_hold", 16'(results()), 16'(res));
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] res_a;
    logic [7:0] res_b;
    logic [7:0] rd;
    logic [3:0] rl;

    initial begin
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = 8'h00;
        bus.len     = 4'd0;
`ifdef SCAN_ABORT_EN
        abort       = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("rst_ser_out", 16'(bus.ser_out), 16'd0);
        check("rst_ser_valid", 16'(bus.ser_valid), 16'd0);
        check("rst_det_rst_n", 16'(bus.det_rst_n), 16'd1);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_results", 16'(results()), 16'd0);
        check("rst_state", 16'(bus.dbg_state), 16'(ST_IDLE));
        @(negedge clock);
        reset = 1'b1;

        // zeros, len 0 -> hits at bits 1, 4, 7
        run_scan(8'h00, 4'd0, 1'b0, res_a);
        check("zeros_hit_count", 16'(res_a[3:0]), 16'd3);
        check("zeros_first_idx", 16'(res_a[6:4]), 16'd1);
        check("zeros_hit_seen", 16'(res_a[7]), 16'd1);

        // all ones: no hits, done still pulses
        run_scan(8'hFF, 4'd8, 1'b0, res_b);
        check("ones_results", 16'(res_b), 16'd0);

        // bits 0,1,0
        run_scan(8'b0000_0010, 4'd3, 1'b0, res_b);
        check("short_hit_count", 16'(res_b[3:0]), 16'd1);
        check("short_first_idx", 16'(res_b[6:4]), 16'd2);

        // start held high through the whole scan
        run_scan(8'h00, 4'd0, 1'b1, res_b);
        check("held_start_same", 16'(res_b), 16'(res_a));
        repeat (3) begin
            @(posedge clock); #1;
            check("held_start_no_extra_done", 16'(bus.done), 16'd0);
        end

        // reset during the 4th SHIFT cycle
        bus.data_in = 8'h00;
        bus.len     = 4'd0;
        bus.start   = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("pre_rst_shifting", 16'(bus.ser_valid), 16'd1);
        reset = 1'b0;
        #1;
        check("midrst_ser_out", 16'(bus.ser_out), 16'd0);
        check("midrst_ser_valid", 16'(bus.ser_valid), 16'd0);
        check("midrst_det_rst_n", 16'(bus.det_rst_n), 16'd1);
        check("midrst_busy", 16'(bus.busy), 16'd0);
        check("midrst_done", 16'(bus.done), 16'd0);
        check("midrst_results", 16'(results()), 16'd0);
        repeat (2) begin
            @(posedge clock); #1;
            check("midrst_no_done", 16'(bus.done), 16'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        run_scan(8'h00, 4'd0, 1'b0, res_b);
        check("post_rst_scan", 16'(res_b), 16'(res_a));

        // random patterns and lengths, including len > 8
        for (int t = 0; t < 4; t++) begin
            rd = 8'($urandom_range(0, 255));
            rl = 4'($urandom_range(0, 15));
            run_scan(rd, rl, 1'b0, res_b);
        end

`ifdef SCAN_ABORT_EN
        bus.data_in = 8'h00;
        bus.len     = 4'd0;
        bus.start   = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_done", 16'(bus.done), 16'd1);
        check("abort_hit_count", 16'(bus.hit_count), 16'd1);
        check("abort_first_idx", 16'(bus.first_hit_idx), 16'd1);
        @(posedge clock); #1;
        check("abort_idle", 16'(bus.busy), 16'd0);
`endif

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
